id_ex: RTL and testbench
========================

Name: id_ex

Overview:
- ID/EX pipeline register between the decoder and the execute stage.
- Registers all decoder outputs every cycle, detects load-use hazards and inserts a bubble for them, and honours an EX-side hold.
- Kills the decoded instruction on a taken jump/branch.
- Generates the stall and flush controls consumed by the PC and IF/ID stages.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word driven on bubble/flush (addi x0,x0,0)
- RST_ADDR, 32'h0000_0000, inst_addr_o value at reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- inst_i  in  32  decoded instruction
- inst_addr_i  in  32  instruction address
- reg1_r_addr_i / reg2_r_addr_i  in  5 each  source register addresses (0 = unused)
- reg1_r_data_i / reg2_r_data_i  in  32 each  source operand data
- reg_w_ena_i  in  1  destination write enable
- reg_w_addr_i  in  5  destination register
- mem_w_ena_i / mem_r_ena_i  in  1 each  store / load flags
- ex_jump_ena_i  in  1  EX resolved taken jump/branch
- ex_hold_i  in  1  EX busy; freeze this register
- inst_o, inst_addr_o  out  32 each  to EX
- reg1_r_addr_o, reg2_r_addr_o  out  5 each  to EX
- reg1_r_data_o, reg2_r_data_o  out  32 each  to EX
- reg_w_ena_o, reg_w_addr_o, mem_w_ena_o, mem_r_ena_o  out  1/5/1/1  to EX
- valid_o  out  1  EX slot holds a real instruction
- stall_o  out  1  hold PC and IF/ID this cycle
- flush_o  out  1  squash IF/ID contents this cycle

Behaviour:
- Clocking: one clock. Reset is synchronous, active-high, named rst.
- Reset (rst=1 at posedge):
  - inst_o=NOP_INST, inst_addr_o=RST_ADDR.
  - All addresses, data and enables = 0; valid_o=0.
- Latency: 1 cycle from ID inputs to EX outputs.
- Load-use hazard (combinational), hz = valid_o & mem_r_ena_o & reg_w_ena_o & (reg_w_addr_o!=0) & ((reg_w_addr_o==reg1_r_addr_i & reg1_r_addr_i!=0) | (reg_w_addr_o==reg2_r_addr_i & reg2_r_addr_i!=0)).
- Combinational outputs:
  - flush_o = ex_jump_ena_i.
  - stall_o = ~ex_jump_ena_i & (hz | ex_hold_i).
- Register update priority at posedge:
  1. rst -> reset values.
  2. ex_jump_ena_i -> load bubble: inst_o=NOP_INST, all enables=0, addresses=0, valid_o=0. inst_addr_o keeps inst_addr_i. Flush beats hold.
  3. ex_hold_i -> all outputs hold their values.
  4. hz -> load bubble. The ID instruction stays in IF/ID via stall_o and re-presents next cycle; hz then clears.
  5. Otherwise -> capture all inputs; valid_o=1.
- A bubble never sets hz in the following cycle, because valid_o=0 and mem_r_ena_o=0.
- Stores whose rs2 matches a load rd stall exactly like ALU uses.
- Back-to-back loads to the same rd: one bubble each.
- rst asserted mid-stall clears state; stall_o depends only on the post-reset register contents.
- No wrap or overflow arithmetic, except the optional counters.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Enabled, adds ports:
  - bubble_cnt_o (out, 32): +1 per posedge taking priority 4.
  - flush_cnt_o (out, 32): +1 per posedge taking priority 2.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Disabled: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - NOP_INST
  - widths INST_W=32, REG_W=32, REG_ADDR_W=5
  - ZERO_REG=5'd0
  - WRITE/READ_ENABLE/DISABLE constants
- Sub-module id_ex_hazard: purely combinational. Inputs are the EX-side load info and the ID rs1/rs2; output is hz. It is reused later for forwarding.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero inputs -> inst_o=32'h13, valid_o=0, stall_o=0, all enables 0.
- Pass-through: add x3,x1,x2 (32'h002081B3, rd=3, rs1=1, rs2=2, data 5/7) at addr 0x10 -> next cycle outputs equal inputs, valid_o=1.
- Load-use: lw x5,0(x1) captured, then ID presents add x6,x5,x2 (rs1=5):
  - stall_o=1 for exactly one cycle, next EX = bubble.
  - Cycle after: add captured, stall_o=0.
  - Repeat with rs1=0, rd=0 -> no stall.
- Flush: ex_jump_ena_i=1 together with ex_hold_i=1 and hz=1 -> flush_o=1, stall_o=0, next EX = bubble with valid_o=0.
- Hold: ex_hold_i=1 for 3 cycles with changing inputs -> outputs frozen, stall_o=1; released -> captures current inputs.
- ID_EX_PERF_CNT_EN: 2 load-use bubbles + 3 flushes -> bubble_cnt_o=2, flush_cnt_o=3. Counter preloaded to 32'hFFFF_FFFF stays saturated.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline widths, NOP encoding and enable constants
package riscv_pipe_pkg;

    localparam int INST_W     = 32;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [INST_W-1:0]     NOP_INST = 32'h0000_0013;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    // Outcome of one ID/EX register update, in priority order below reset.
    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_CAPTURE
    } id_ex_upd_e;

endpackage

// File: rtl/id_ex_hazard.sv
// rtl/id_ex_hazard.sv - combinational load-use match between the EX-stage load and ID sources
module id_ex_hazard
    import riscv_pipe_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_mem_r_ena,
    input  logic                  ex_reg_w_ena,
    input  logic [REG_ADDR_W-1:0] ex_reg_w_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  hz
);

    logic rs1_match;
    logic rs2_match;

    // x0 is never a real dependency, on either side.
    assign rs1_match = (ex_reg_w_addr == rs1_addr) && (rs1_addr != ZERO_REG);
    assign rs2_match = (ex_reg_w_addr == rs2_addr) && (rs2_addr != ZERO_REG);

    assign hz = ex_valid && (ex_mem_r_ena == READ_ENABLE) && (ex_reg_w_ena == WRITE_ENABLE)
              && (ex_reg_w_addr != ZERO_REG) && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex.sv
// rtl/id_ex.sv - ID/EX pipeline register with load-use bubble, EX hold and jump flush
// Optional saturating bubble/flush counters under ID_EX_PERF_CNT_EN.
module id_ex
    import riscv_pipe_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = riscv_pipe_pkg::NOP_INST,
    parameter logic [INST_W-1:0] RST_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_W-1:0]     inst_i,
    input  logic [INST_W-1:0]     inst_addr_i,
    input  logic [REG_ADDR_W-1:0] reg1_r_addr_i,
    input  logic [REG_ADDR_W-1:0] reg2_r_addr_i,
    input  logic [REG_W-1:0]      reg1_r_data_i,
    input  logic [REG_W-1:0]      reg2_r_data_i,
    input  logic                  reg_w_ena_i,
    input  logic [REG_ADDR_W-1:0] reg_w_addr_i,
    input  logic                  mem_w_ena_i,
    input  logic                  mem_r_ena_i,
    input  logic                  ex_jump_ena_i,
    input  logic                  ex_hold_i,
    output logic [INST_W-1:0]     inst_o,
    output logic [INST_W-1:0]     inst_addr_o,
    output logic [REG_ADDR_W-1:0] reg1_r_addr_o,
    output logic [REG_ADDR_W-1:0] reg2_r_addr_o,
    output logic [REG_W-1:0]      reg1_r_data_o,
    output logic [REG_W-1:0]      reg2_r_data_o,
    output logic                  reg_w_ena_o,
    output logic [REG_ADDR_W-1:0] reg_w_addr_o,
    output logic                  mem_w_ena_o,
    output logic                  mem_r_ena_o,
    output logic                  valid_o,
    output logic                  stall_o,
    output logic                  flush_o
`ifdef ID_EX_PERF_CNT_EN
   ,output logic [31:0]           bubble_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    logic       hz;
    id_ex_upd_e upd;

    id_ex_hazard u_hazard (
        .ex_valid      (valid_o),
        .ex_mem_r_ena  (mem_r_ena_o),
        .ex_reg_w_ena  (reg_w_ena_o),
        .ex_reg_w_addr (reg_w_addr_o),
        .rs1_addr      (reg1_r_addr_i),
        .rs2_addr      (reg2_r_addr_i),
        .hz            (hz)
    );

    assign flush_o = ex_jump_ena_i;
    assign stall_o = !ex_jump_ena_i && (hz || ex_hold_i);

    // A taken jump wins over hold: the younger instruction must die even if EX is busy.
    always_comb begin
        upd = UPD_CAPTURE;
        if (ex_jump_ena_i)
            upd = UPD_FLUSH;
        else if (ex_hold_i)
            upd = UPD_HOLD;
        else if (hz)
            upd = UPD_BUBBLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o        <= NOP_INST;
            inst_addr_o   <= RST_ADDR;
            reg1_r_addr_o <= ZERO_REG;
            reg2_r_addr_o <= ZERO_REG;
            reg1_r_data_o <= '0;
            reg2_r_data_o <= '0;
            reg_w_ena_o   <= WRITE_DISABLE;
            reg_w_addr_o  <= ZERO_REG;
            mem_w_ena_o   <= WRITE_DISABLE;
            mem_r_ena_o   <= READ_DISABLE;
            valid_o       <= 1'b0;
        end else begin
            case (upd)
                UPD_FLUSH, UPD_BUBBLE: begin
                    inst_o        <= NOP_INST;
                    inst_addr_o   <= inst_addr_i;
                    reg1_r_addr_o <= ZERO_REG;
                    reg2_r_addr_o <= ZERO_REG;
                    reg1_r_data_o <= '0;
                    reg2_r_data_o <= '0;
                    reg_w_ena_o   <= WRITE_DISABLE;
                    reg_w_addr_o  <= ZERO_REG;
                    mem_w_ena_o   <= WRITE_DISABLE;
                    mem_r_ena_o   <= READ_DISABLE;
                    valid_o       <= 1'b0;
                end
                UPD_HOLD: ;
                default: begin
                    inst_o        <= inst_i;
                    inst_addr_o   <= inst_addr_i;
                    reg1_r_addr_o <= reg1_r_addr_i;
                    reg2_r_addr_o <= reg2_r_addr_i;
                    reg1_r_data_o <= reg1_r_data_i;
                    reg2_r_data_o <= reg2_r_data_i;
                    reg_w_ena_o   <= reg_w_ena_i;
                    reg_w_addr_o  <= reg_w_addr_i;
                    mem_w_ena_o   <= mem_w_ena_i;
                    mem_r_ena_o   <= mem_r_ena_i;
                    valid_o       <= 1'b1;
                end
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            if (upd == UPD_BUBBLE && bubble_cnt_o != 32'hFFFF_FFFF)
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            if (upd == UPD_FLUSH && flush_cnt_o != 32'hFFFF_FFFF)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex.sv
// tb/tb_id_ex.sv - directed self-checking bench for id_ex
module tb_id_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i, reg1_r_data_i, reg2_r_data_i;
    logic [4:0]  reg1_r_addr_i, reg2_r_addr_i, reg_w_addr_i;
    logic        reg_w_ena_i, mem_w_ena_i, mem_r_ena_i, ex_jump_ena_i, ex_hold_i;
    logic [31:0] inst_o, inst_addr_o, reg1_r_data_o, reg2_r_data_o;
    logic [4:0]  reg1_r_addr_o, reg2_r_addr_o, reg_w_addr_o;
    logic        reg_w_ena_o, mem_w_ena_o, mem_r_ena_o, valid_o, stall_o, flush_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_o, flush_cnt_o;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    id_ex dut (
        .clk           (clk),
        .rst           (rst),
        .inst_i        (inst_i),
        .inst_addr_i   (inst_addr_i),
        .reg1_r_addr_i (reg1_r_addr_i),
        .reg2_r_addr_i (reg2_r_addr_i),
        .reg1_r_data_i (reg1_r_data_i),
        .reg2_r_data_i (reg2_r_data_i),
        .reg_w_ena_i   (reg_w_ena_i),
        .reg_w_addr_i  (reg_w_addr_i),
        .mem_w_ena_i   (mem_w_ena_i),
        .mem_r_ena_i   (mem_r_ena_i),
        .ex_jump_ena_i (ex_jump_ena_i),
        .ex_hold_i     (ex_hold_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .reg1_r_addr_o (reg1_r_addr_o),
        .reg2_r_addr_o (reg2_r_addr_o),
        .reg1_r_data_o (reg1_r_data_o),
        .reg2_r_data_o (reg2_r_data_o),
        .reg_w_ena_o   (reg_w_ena_o),
        .reg_w_addr_o  (reg_w_addr_o),
        .mem_w_ena_o   (mem_w_ena_o),
        .mem_r_ena_o   (mem_r_ena_o),
        .valid_o       (valid_o),
        .stall_o       (stall_o),
        .flush_o       (flush_o)
`ifdef ID_EX_PERF_CNT_EN
       ,.bubble_cnt_o  (bubble_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] addr,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic we, input logic [4:0] rd,
                         input logic mw, input logic mr);
        inst_i        = inst;
        inst_addr_i   = addr;
        reg1_r_addr_i = rs1;
        reg2_r_addr_i = rs2;
        reg1_r_data_i = d1;
        reg2_r_data_i = d2;
        reg_w_ena_i   = we;
        reg_w_addr_i  = rd;
        mem_w_ena_i   = mw;
        mem_r_ena_i   = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_inst"}, inst_o, 32'h0000_0013);
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_en"}, {29'd0, reg_w_ena_o, mem_w_ena_o, mem_r_ena_o}, 32'd0);
        check({tag, "_addr"}, {17'd0, reg1_r_addr_o, reg2_r_addr_o, reg_w_addr_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ex_jump_ena_i = 1'b0;
        ex_hold_i     = 1'b0;
        drive(32'h0020_81B3, 32'h10, 5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 5'd3, 1'b1, 1'b1);
        #1;
        tick();
        tick();
        check_bubble("rst");
        check("rst_pc", inst_addr_o, 32'h0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);

        // add x3,x1,x2 passes straight through
        rst = 1'b0;
        drive(32'h0020_81B3, 32'h10, 5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        check("pt_inst", inst_o, 32'h0020_81B3);
        check("pt_pc", inst_addr_o, 32'h10);
        check("pt_rs", {22'd0, reg1_r_addr_o, reg2_r_addr_o}, {22'd0, 5'd1, 5'd2});
        check("pt_d1", reg1_r_data_o, 32'd5);
        check("pt_d2", reg2_r_data_o, 32'd7);
        check("pt_rd", {26'd0, reg_w_ena_o, reg_w_addr_o}, {26'd0, 1'b1, 5'd3});
        check("pt_valid", {31'd0, valid_o}, 32'd1);

        // lw x5,0(x1) then add x6,x5,x2
        drive(32'h0000_A283, 32'h14, 5'd1, 5'd0, 32'd5, 32'd0, 1'b1, 5'd5, 1'b0, 1'b1);
        #1 check("lw_nostall", {31'd0, stall_o}, 32'd0);
        tick();
        check("lw_mr", {31'd0, mem_r_ena_o}, 32'd1);
        drive(32'h0022_8333, 32'h18, 5'd5, 5'd2, 32'd0, 32'd7, 1'b1, 5'd6, 1'b0, 1'b0);
        #1 check("lu_stall", {31'd0, stall_o}, 32'd1);
        check("lu_flush", {31'd0, flush_o}, 32'd0);
        tick();
        check_bubble("lu_bub");
        check("lu_stall_clr", {31'd0, stall_o}, 32'd0);
        tick();
        check("lu_inst", inst_o, 32'h0022_8333);
        check("lu_pc", inst_addr_o, 32'h18);
        check("lu_valid", {31'd0, valid_o}, 32'd1);

        // load to x0 followed by a reader of x0: no hazard
        drive(32'h0000_A003, 32'h1C, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1);
        tick();
        drive(32'h0000_0033, 32'h20, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check("x0_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("x0_valid", {31'd0, valid_o}, 32'd1);

        // sw x5,0(x1) after lw x5: rs2 match stalls too
        drive(32'h0000_A283, 32'h24, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 1'b0, 1'b1);
        tick();
        drive(32'h0050_A023, 32'h28, 5'd1, 5'd5, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        #1 check("st_stall", {31'd0, stall_o}, 32'd1);
        tick();
        check_bubble("st_bub");
        tick();
        check("st_mw", {31'd0, mem_w_ena_o}, 32'd1);

        // flush with hold and hazard all active: flush wins
        drive(32'h0000_A283, 32'h2C, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 1'b0, 1'b1);
        tick();
        drive(32'h0022_8333, 32'h30, 5'd5, 5'd2, 32'd0, 32'd0, 1'b1, 5'd6, 1'b0, 1'b0);
        ex_jump_ena_i = 1'b1;
        ex_hold_i     = 1'b1;
        #1 check("fl_flush", {31'd0, flush_o}, 32'd1);
        check("fl_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check_bubble("fl_bub");
        check("fl_pc", inst_addr_o, 32'h30);
        tick();
        tick();
        ex_jump_ena_i = 1'b0;
        ex_hold_i     = 1'b0;

        // EX hold for three cycles with changing ID inputs
        drive(32'h0020_81B3, 32'h40, 5'd1, 5'd2, 32'd11, 32'd22, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        ex_hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_0033 + i, 32'h44 + 4 * i, 5'd7, 5'd8, i, i, 1'b1, 5'd9, 1'b0, 1'b0);
            #1 check("hd_stall", {31'd0, stall_o}, 32'd1);
            tick();
            check("hd_pc", inst_addr_o, 32'h40);
            check("hd_d1", reg1_r_data_o, 32'd11);
        end
        ex_hold_i = 1'b0;
        tick();
        check("hd_rel_pc", inst_addr_o, 32'h4C);
        check("hd_rel_rd", {27'd0, reg_w_addr_o}, 32'd9);

`ifdef ID_EX_PERF_CNT_EN
        check("cnt_bubble", bubble_cnt_o, 32'd2);
        check("cnt_flush", flush_cnt_o, 32'd3);
`endif

        // reset during a load-use stall
        drive(32'h0000_A283, 32'h50, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 1'b0, 1'b1);
        tick();
        drive(32'h0022_8333, 32'h54, 5'd5, 5'd2, 32'd0, 32'd0, 1'b1, 5'd6, 1'b0, 1'b0);
        #1 check("rs_stall", {31'd0, stall_o}, 32'd1);
        rst = 1'b1;
        tick();
        check("rs_stall_clr", {31'd0, stall_o}, 32'd0);
        check_bubble("rs_bub");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
